imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered immediate generator for the decode stage. Handles every RV32I/RV64I immediate format plus shamt and CSR zimm.
//  XLEN-parametrised, sign/zero-extends to XLEN. Has a 2-entry valid/ready skid buffer so decode->execute can stall without
//  combinational ready paths. Successor to the 2-bit-select combinational extender.
// PARAMETERS
//  XLEN   32  output width; legal values 32 or 64
//  TAG_W  5   width of the sideband tag carried alongside the immediate (e.g. rd/ROB id)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous drop of all buffered entries
//  in_valid   in   1      upstream presents instr
//  in_ready   out  1      block can accept (registered; equals "skid entry empty")
//  in_instr   in   32     raw instruction word
//  in_sel     in   3      immediate format select (encoding below)
//  in_tag     in   TAG_W  sideband, passed through unchanged
//  out_valid  out  1      out_imm/out_tag/out_err valid
//  out_ready  in   1      downstream accepts
//  out_imm    out  XLEN   extended immediate
//  out_tag    out  TAG_W  tag of the same entry
//  out_err    out  1      illegal select or misaligned branch/jump target (only with IMMGEN_CHECK_EN)
// BEHAVIOUR
//  Select encoding (shared pkg): 000 I {sx instr[31:20]}; 001 S {sx instr[31:25],[11:7]}; 010 B {sx [31],[7],[30:25],[11:8],0};
//   011 J {sx [31],[19:12],[20],[30:21],0}; 100 U {sx [31:12],12'b0} (sx only matters at XLEN=64);
//   101 SHAMT zero-ext instr[24:20] (XLEN=32) / instr[25:20] (XLEN=64); 110 ZIMM zero-ext instr[19:15]; 111 reserved -> imm 0.
//  Immediate computed combinationally from in_*, then registered: latency exactly 1 cycle, in accept -> out_valid.
//  States (buffer occupancy): EMPTY (out_valid=0,in_ready=1); ONE (out_valid=1,in_ready=1); TWO (out_valid=1,in_ready=0).
//   EMPTY: in fire -> ONE.
//   ONE: in fire & out fire -> ONE (main reg reloaded); in fire only -> TWO (new entry into skid); out fire only -> EMPTY.
//   TWO: out fire -> ONE, skid moves to main reg; in_ready=0 so no accept.
//  fire = valid & ready on that interface. Output order = acceptance order; no entry dropped or duplicated.
//  out_* held stable while out_valid & !out_ready.
//  flush: next state EMPTY, out_valid=0, in_ready=1; a simultaneous in fire is discarded. flush has priority over all.
//  Reset (async assert, sync-released by top): state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0.
//  Reset mid-transfer: all buffered entries lost, no out_valid pulse after deassert.
//  Data regs need not be cleared on pop; only valid bits are reset-critical (out_imm still 0 after reset).
// CONFIGURATION
//  IMMGEN_CHECK_EN defined: out_err=1 for sel 111, or for sel B/J when instr[8] (B) / instr[21] (J) set (target not 4-byte aligned,
//   no-RVC core); err registered and buffered with its entry.
//  Not defined: out_err tied 0; sel 111 still yields imm 0; no check logic synthesised.
// STRUCTURE
//  Package imm_gen_pkg: IMM_I..IMM_RSVD localparams for sel encoding, state encoding, XLEN legality check.
//  Sub-module imm_gen_core: pure combinational format mux/extender (instr, sel -> imm, err). Instantiated once at input side.
//  Top holds the 2-entry skid buffer + FSM.
// TESTING
//  Formats XLEN=32, out_ready=1: I 0xFFF00093 -> 0xFFFFFFFF; S 0xFE20AE23 -> 0xFFFFFFFC; B 0xFE000CE3 -> 0xFFFFFFF8;
//   J 0x008000EF -> 0x00000008; U 0x123450B7 -> 0x12345000; each 1 cycle after accept.
//  XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; SHAMT with instr[25]=1, [24:20]=0 -> 0x20.
//  Backpressure: out_ready=0, push A,B -> in_ready=0 after B; C held off; release -> A,B,C in order, tags intact.
//  Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entries never appear.
//  Reset asserted mid-stream (state ONE) -> out_valid=0 immediately, out_imm=0, in_ready=1.
//  IMMGEN_CHECK_EN: sel 111 -> imm 0, err 1; B with instr[8]=1 -> err 1; macro undefined -> err 0 for both.
//  Random: valid/ready toggled randomly 10k cycles, scoreboard vs imm_gen_core model, in-order, no loss.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared immediate-format select encoding, skid-buffer state
//               encoding and XLEN legality helper for imm_gen_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_J     = 3'b011;
   localparam logic [2:0] IMM_U     = 3'b100;
   localparam logic [2:0] IMM_SHAMT = 3'b101;
   localparam logic [2:0] IMM_ZIMM  = 3'b110;
   localparam logic [2:0] IMM_RSVD  = 3'b111;

   // bit0 = out_valid, bit1 = buffer full; outputs decode straight off the flops
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b11;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen_core.sv
// ============================================================================
// Module      : imm_gen_core
// Description : Combinational RV32I/RV64I immediate format mux and extender.
//               Optional target/select check under `IMMGEN_CHECK_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  logic [2:0]      sel_i,
   output logic [XLEN-1:0] imm_o,
   output logic            err_o
);

   // opcode bits carry no immediate data
   logic w_unused_opcode;
   assign w_unused_opcode = ^instr_i[6:0];

   always_comb begin
      imm_o = '0;
      case (sel_i)
         IMM_I:     imm_o = XLEN'($signed(instr_i[31:20]));
         IMM_S:     imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
         IMM_B:     imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                           instr_i[11:8], 1'b0}));
         IMM_J:     imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                           instr_i[30:21], 1'b0}));
         IMM_U:     imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
         IMM_SHAMT: begin
            if (XLEN == 32) imm_o = XLEN'(instr_i[24:20]);
            else            imm_o = XLEN'(instr_i[25:20]);
         end
         IMM_ZIMM:  imm_o = XLEN'(instr_i[19:15]);
         default:   imm_o = '0;
      endcase
   end

`ifdef IMMGEN_CHECK_EN
   // no-RVC core: branch/jump targets must be 4-byte aligned
   always_comb begin
      err_o = (sel_i == IMM_RSVD)
           || ((sel_i == IMM_B) && instr_i[8])
           || ((sel_i == IMM_J) && instr_i[21]);
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate generator with a 2-entry valid/ready
//               skid buffer. Optional error check via `IMMGEN_CHECK_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_instr_i,
   input  logic [2:0]       in_sel_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  out_imm_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             out_err_o
);

   if (!xlen_legal(XLEN)) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   logic [1:0]       state_q, state_d;
   logic [XLEN-1:0]  w_core_imm;
   logic             w_core_err;
   logic             w_in_fire, w_out_fire;
   logic             w_load_main_in, w_load_main_skid, w_load_skid;

   logic [XLEN-1:0]  main_imm_q, skid_imm_q;
   logic [TAG_W-1:0] main_tag_q, skid_tag_q;
   logic             main_err_q, skid_err_q;

   imm_gen_core #(.XLEN(XLEN)) u_core (
      .instr_i (in_instr_i),
      .sel_i   (in_sel_i),
      .imm_o   (w_core_imm),
      .err_o   (w_core_err)
   );

   // fires taken from the state flops to keep ready/valid free of comb loops
   assign w_in_fire  = in_valid_i  & ~state_q[1];
   assign w_out_fire = out_ready_i &  state_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (w_in_fire) state_d = ST_ONE;
            ST_ONE: begin
               if (w_in_fire && !w_out_fire)      state_d = ST_TWO;
               else if (!w_in_fire && w_out_fire) state_d = ST_EMPTY;
            end
            ST_TWO:   if (w_out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid_o      = state_q[0];
      in_ready_o       = ~state_q[1];
      w_load_main_in   = 1'b0;
      w_load_skid      = 1'b0;
      w_load_main_skid = 1'b0;
      if (!flush_i) begin
         w_load_main_in   = w_in_fire && ((state_q == ST_EMPTY)
                                       || ((state_q == ST_ONE) && w_out_fire));
         w_load_skid      = w_in_fire && (state_q == ST_ONE) && !w_out_fire;
         w_load_main_skid = (state_q == ST_TWO) && w_out_fire;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_imm_q <= '0;
         main_tag_q <= '0;
         main_err_q <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         if (w_load_main_in) begin
            main_imm_q <= w_core_imm;
            main_tag_q <= in_tag_i;
            main_err_q <= w_core_err;
         end else if (w_load_main_skid) begin
            main_imm_q <= skid_imm_q;
            main_tag_q <= skid_tag_q;
            main_err_q <= skid_err_q;
         end
         if (w_load_skid) begin
            skid_imm_q <= w_core_imm;
            skid_tag_q <= in_tag_i;
            skid_err_q <= w_core_err;
         end
      end
   end

   assign out_imm_o = main_imm_q;
   assign out_tag_o = main_tag_q;
   assign out_err_o = main_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe (XLEN 32 and 64 instances
//               side by side); honours `IMMGEN_CHECK_EN` for error expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_sel;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        rdy32, vld32, err32;
   logic [31:0] imm32;
   logic [4:0]  tag32;
   logic        rdy64, vld64, err64;
   logic [63:0] imm64;
   logic [4:0]  tag64;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] imm32;
      logic [63:0] imm64;
      logic [4:0]  tag;
      logic        err;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy32), .in_instr_i(in_instr),
      .in_sel_i(in_sel), .in_tag_i(in_tag),
      .out_valid_o(vld32), .out_ready_i(out_ready),
      .out_imm_o(imm32), .out_tag_o(tag32), .out_err_o(err32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy64), .in_instr_i(in_instr),
      .in_sel_i(in_sel), .in_tag_i(in_tag),
      .out_valid_o(vld64), .out_ready_i(out_ready),
      .out_imm_o(imm64), .out_tag_o(tag64), .out_err_o(err64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference immediate from the ISA field layout, as a signed integer value
   function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input int xl);
      longint v;
      case (s)
         3'd0: v = longint'($signed(i[31:20]));
         3'd1: v = longint'($signed({i[31:25], i[11:7]}));
         3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         3'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         3'd4: v = longint'($signed(i[31:12])) * 4096;
         3'd5: v = (xl == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
         3'd6: v = longint'(i[19:15]);
         default: v = 0;
      endcase
      if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   function automatic logic ref_err(input logic [31:0] i, input logic [2:0] s);
`ifdef IMMGEN_CHECK_EN
      return (s == 3'd7) || (s == 3'd2 && i[8]) || (s == 3'd3 && i[21]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_model();
      chk("vld32", {63'd0, vld32}, {63'd0, q.size() > 0});
      chk("rdy32", {63'd0, rdy32}, {63'd0, q.size() < 2});
      chk("vld64", {63'd0, vld64}, {63'd0, q.size() > 0});
      chk("rdy64", {63'd0, rdy64}, {63'd0, q.size() < 2});
      if (q.size() > 0) begin
         chk("imm32", {32'd0, imm32}, q[0].imm32);
         chk("imm64", imm64, q[0].imm64);
         chk("tag32", {59'd0, tag32}, {59'd0, q[0].tag});
         chk("tag64", {59'd0, tag64}, {59'd0, q[0].tag});
         chk("err32", {63'd0, err32}, {63'd0, q[0].err});
         chk("err64", {63'd0, err64}, {63'd0, q[0].err});
      end
   endtask

   // Apply one cycle of inputs (called right after a negedge), update the
   // queue model for the coming edge, then check outputs at the next negedge.
   task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] s,
                        input logic [4:0] t, input bit ordy, input bit fl);
      ent_t e;
      bit   inf, outf;
      in_valid = v; in_instr = ins; in_sel = s; in_tag = t;
      out_ready = ordy; flush = fl;
      inf  = v && (q.size() < 2);
      outf = ordy && (q.size() > 0);
      if (fl) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) begin
            e.imm32 = ref_imm(ins, s, 32);
            e.imm64 = ref_imm(ins, s, 64);
            e.tag   = t;
            e.err   = ref_err(ins, s);
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input bit ordy);
      drive(1'b0, 32'd0, 3'd0, 5'd0, ordy, 1'b0);
   endtask

   logic [31:0] fmt_instr [5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h008000EF, 32'h123450B7};
   logic [31:0] fmt_exp   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000008, 32'h12345000};
   string       fmt_name  [5] = '{"fmt_I", "fmt_S", "fmt_B", "fmt_J", "fmt_U"};

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
      in_sel = '0; in_tag = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld",  {63'd0, vld32}, 64'd0);
      chk("rst_rdy",  {63'd0, rdy32}, 64'd1);
      chk("rst_imm",  {32'd0, imm32}, 64'd0);
      chk("rst_tag",  {59'd0, tag32}, 64'd0);
      chk("rst_err",  {63'd0, err32}, 64'd0);
      rst_n = 1'b1;
      idle(1'b1);

      // Formats at XLEN=32, one cycle after accept
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, fmt_instr[k], k[2:0], k[4:0], 1'b1, 1'b0);
         chk(fmt_name[k], {32'd0, imm32}, {32'd0, fmt_exp[k]});
      end
      idle(1'b1);

      // XLEN=64 sign extension of U and 6-bit shamt
      drive(1'b1, 32'h800000B7, 3'd4, 5'd7, 1'b1, 1'b0);
      chk("u64", imm64, 64'hFFFFFFFF80000000);
      drive(1'b1, 32'h02000013, 3'd5, 5'd8, 1'b1, 1'b0);
      chk("shamt64", imm64, 64'h20);
      chk("shamt32", {32'd0, imm32}, 64'h0);
      idle(1'b1);

      // Backpressure: A,B fill the buffer, C held off, then drained in order
      drive(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b0, 1'b0);
      drive(1'b1, 32'h123450B7, 3'd4, 5'd2, 1'b0, 1'b0);
      chk("bp_full", {63'd0, rdy32}, 64'd0);
      drive(1'b1, 32'h008000EF, 3'd3, 5'd3, 1'b0, 1'b0);
      chk("bp_headA", {59'd0, tag32}, 64'd1);
      drive(1'b1, 32'h008000EF, 3'd3, 5'd3, 1'b1, 1'b0);
      chk("bp_headB", {59'd0, tag32}, 64'd2);
      drive(1'b1, 32'h008000EF, 3'd3, 5'd3, 1'b1, 1'b0);
      chk("bp_headC", {59'd0, tag32}, 64'd3);
      idle(1'b1);
      idle(1'b1);

      // Flush while full with a simultaneous push
      drive(1'b1, 32'hFFF00093, 3'd0, 5'd4, 1'b0, 1'b0);
      drive(1'b1, 32'hFE20AE23, 3'd1, 5'd5, 1'b0, 1'b0);
      drive(1'b1, 32'hFE000CE3, 3'd2, 5'd6, 1'b0, 1'b1);
      chk("flush_vld", {63'd0, vld32}, 64'd0);
      chk("flush_rdy", {63'd0, rdy32}, 64'd1);
      idle(1'b1);
      chk("flush_gone", {63'd0, vld32}, 64'd0);

      // Asynchronous reset with one entry buffered
      drive(1'b1, 32'h123450B7, 3'd4, 5'd9, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", {63'd0, vld32}, 64'd0);
      chk("arst_imm", {32'd0, imm32}, 64'd0);
      chk("arst_rdy", {63'd0, rdy32}, 64'd1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      chk("arst_nopulse", {63'd0, vld32}, 64'd0);

      // Reserved select and misaligned branch
      drive(1'b1, 32'hFFFFFFFF, 3'd7, 5'd10, 1'b1, 1'b0);
      chk("rsvd_imm", {32'd0, imm32}, 64'd0);
`ifdef IMMGEN_CHECK_EN
      chk("rsvd_err", {63'd0, err32}, 64'd1);
`else
      chk("rsvd_err", {63'd0, err32}, 64'd0);
`endif
      drive(1'b1, 32'h00000163, 3'd2, 5'd11, 1'b1, 1'b0);
`ifdef IMMGEN_CHECK_EN
      chk("b_misal_err", {63'd0, err32}, 64'd1);
`else
      chk("b_misal_err", {63'd0, err32}, 64'd0);
`endif
      idle(1'b1);

      // Random traffic against the queue model
      for (int n = 0; n < 10000; n++) begin
         drive($urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 7)),
               5'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
      for (int n = 0; n < 4; n++) idle(1'b1);
      chk("drained", {63'd0, vld32}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
